btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
Input conditioner for the five board push-buttons (U/D/L/R/C), placed directly downstream of the raw button pins and upstream of the cursor/game FSM in the top module.
- Synchronises each button, debounces it and produces one-cycle press pulses.
- Auto-repeats the direction keys while they are held.
- Arbitrates simultaneous presses into a single encoded key event per cycle for the game logic.

Parameters:
N_BTN, 5, number of buttons; bit order [0]=U [1]=D [2]=L [3]=R [4]=C
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range >=1
REPEAT_DELAY, 40000000, cycles a key is held before the first auto-repeat pulse (0.4 s)
REPEAT_RATE, 10000000, cycles between subsequent auto-repeat pulses (0.1 s)
REPEAT_MASK, 5'b01111, buttons eligible for auto-repeat (C excluded)

Ports:
CLK  in  1  system clock, 100 MHz
RST  in  1  asynchronous reset, active-high
btn_raw  in  N_BTN  unsynchronised button pins, 1 = pressed
btn_level  out  N_BTN  debounced button state
btn_press  out  N_BTN  one-cycle pulse per accepted press or auto-repeat
key_valid  out  1  one-cycle pulse: a key event is presented on key_code
key_code  out  3  0=U 1=D 2=L 3=R 4=C; holds its last value when key_valid=0

Behaviour:
- Reset: while RST=1, all synchroniser flops, counters, btn_level, btn_press, key_valid and key_code clear to 0 immediately. No state survives a reset.
- Synchroniser: 2-FF per bit, giving sync[i].
- Debounce, per bit:
  - cnt clears whenever sync[i]==btn_level[i].
  - Otherwise cnt increments.
  - On the edge where sync[i] has differed from btn_level[i] for DEBOUNCE_CYCLES consecutive edges, btn_level[i] takes sync[i] and cnt clears.
  - Any agreeing sample restarts the count.
  - Latency from raw change to btn_level change is DEBOUNCE_CYCLES+2 edges.
- Press pulse: btn_press[i]=1 in the same cycle that btn_level[i] first becomes 1. A release produces no pulse.
- Auto-repeat (bits with REPEAT_MASK[i]=1):
  - A hold timer starts at the press edge.
  - The first repeat pulse occurs REPEAT_DELAY cycles after the initial press pulse.
  - Further pulses follow every REPEAT_RATE cycles while btn_level[i]=1.
  - Release (btn_level[i]=0) clears the timer in the same edge; no pulse is issued on the release cycle.
  - Masked-off bits produce exactly one pulse per press.
- Arbiter: registered, one cycle after btn_press.
  - If any btn_press bit is set, key_valid=1 and key_code=encoded winner.
  - Priority: C > U > D > L > R.
  - Losing presses in the same cycle are dropped, not queued.
  - btn_press stays raw, so all bits remain visible on btn_press.
- Counter widths: $clog2 of the respective parameter. Counters saturate-free by construction, and no wrap is observable.
- Independence: each bit's debounce and repeat logic is independent of the others.

Test Plan:
(Bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.)
1. Glitch: btn_raw[0] high for 3 cycles, then low -> btn_level, btn_press and key_valid all stay 0.
2. Clean press: btn_raw[2] high for 12 cycles, then low.
   - btn_level[2] rises 6 edges after the raw rise.
   - btn_press=5'b00100 for exactly one cycle.
   - Next cycle: key_valid=1, key_code=2.
   - btn_level[2] falls 6 edges after the raw fall, with no pulse on release.
3. Auto-repeat: btn_raw[1] held 60 cycles -> btn_press[1] pulses at press edge P, then P+20, P+28, P+36, P+44, P+52. Each pulse is followed by key_valid with key_code=1.
4. No repeat on C: btn_raw[4] held 60 cycles -> exactly one btn_press[4] pulse and one key_valid with key_code=4.
5. Simultaneous: btn_raw[0] and btn_raw[3] rise on the same edge.
   - btn_press=5'b01001 for one cycle.
   - A single key_valid follows, with key_code=0.
   - Repeat with bits 4 and 0 -> key_code=4.
6. Reset mid-hold: btn_raw[3] held, RST pulsed for 2 cycles at P+10.
   - All outputs are 0 during RST.
   - After release, with the button still held, btn_press[3] pulses 6 edges later.
   - The next repeat follows 20 cycles after that pulse.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button front end: 2-FF synchroniser, per-bit debounce, press/auto-repeat
// pulses and a registered priority arbiter that emits one key event per cycle.
module btn_conditioner #(
  parameter int               N_BTN           = 5,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter int               REPEAT_DELAY    = 40000000,
  parameter int               REPEAT_RATE     = 10000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b01111
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic             key_valid,
  output logic [2:0]       key_code
);

  localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HT_W     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HT_W-1:0] DELAY_LAST = HT_W'(REPEAT_DELAY - 1);
  localparam logic [HT_W-1:0] RATE_LAST  = HT_W'(REPEAT_RATE - 1);

  typedef enum logic {PH_DELAY, PH_RATE} phase_e;

  logic [N_BTN-1:0] syncMeta_q, sync_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [DB_W-1:0]  dbCnt_q [N_BTN];
  logic [DB_W-1:0]  dbCnt_d [N_BTN];
  logic [HT_W-1:0]  hold_q  [N_BTN];
  logic [HT_W-1:0]  hold_d  [N_BTN];
  phase_e           phase_q [N_BTN];
  phase_e           phase_d [N_BTN];
  logic             keyValid_q, keyValid_d;
  logic [2:0]       keyCode_q, keyCode_d;

  // The hold timer counts edges since the last pulse; a falling level clears it
  // on the same edge so no pulse can slip out with the release.
  always_comb begin
    level_d = level_q;
    press_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      dbCnt_d[i] = '0;
      hold_d[i]  = '0;
      phase_d[i] = PH_DELAY;
      if (sync_q[i] != level_q[i]) begin
        if (dbCnt_q[i] == DB_LAST) level_d[i] = sync_q[i];
        else                       dbCnt_d[i] = dbCnt_q[i] + 1'b1;
      end
      if (level_d[i] && !level_q[i]) begin
        press_d[i] = 1'b1;
      end else if (level_d[i] && level_q[i] && REPEAT_MASK[i]) begin
        if (hold_q[i] == ((phase_q[i] == PH_DELAY) ? DELAY_LAST : RATE_LAST)) begin
          press_d[i] = 1'b1;
          phase_d[i] = PH_RATE;
        end else begin
          hold_d[i]  = hold_q[i] + 1'b1;
          phase_d[i] = phase_q[i];
        end
      end
    end
  end

  // C (top bit) beats everything; among the rest the lowest index wins.
  always_comb begin
    keyValid_d = |press_q;
    keyCode_d  = keyCode_q;
    for (int i = N_BTN - 2; i >= 0; i--) begin
      if (press_q[i]) keyCode_d = 3'(i);
    end
    if (press_q[N_BTN-1]) keyCode_d = 3'(N_BTN - 1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      syncMeta_q <= '0;
      sync_q     <= '0;
      level_q    <= '0;
      press_q    <= '0;
      keyValid_q <= 1'b0;
      keyCode_q  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        dbCnt_q[i] <= '0;
        hold_q[i]  <= '0;
        phase_q[i] <= PH_DELAY;
      end
    end else begin
      syncMeta_q <= btn_raw;
      sync_q     <= syncMeta_q;
      level_q    <= level_d;
      press_q    <= press_d;
      keyValid_q <= keyValid_d;
      keyCode_q  <= keyCode_d;
      for (int i = 0; i < N_BTN; i++) begin
        dbCnt_q[i] <= dbCnt_d[i];
        hold_q[i]  <= hold_d[i];
        phase_q[i] <= phase_d[i];
      end
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;
  assign key_valid = keyValid_q;
  assign key_code  = keyCode_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus random button
// activity, all compared against a behavioural model built from the key rules.
module tb_btn_conditioner;

  localparam int N    = 5;
  localparam int DEB  = 4;
  localparam int DLY  = 20;
  localparam int RATE = 8;
  localparam int HLEN = DEB + 2;
  localparam int LOGN = 128;

  logic         CLK = 1'b0;
  logic         RST;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic         key_valid;
  logic [2:0]   key_code;

  btn_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY),
    .REPEAT_RATE(RATE), .REPEAT_MASK(5'b01111)
  ) dut (
    .CLK(CLK), .RST(RST), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .key_valid(key_valid), .key_code(key_code)
  );

  always #5 CLK = ~CLK;

  int checkCount = 0;
  int errorCount = 0;

  // Model state: raw sample history (index k = k edges ago), outputs, press times.
  bit           rawHist [N][HLEN];
  logic [N-1:0] mLevel, mPress;
  logic         mValid;
  logic [2:0]   mCode;
  int           pressTime [N];
  int           tNow = 0;
  int           prio [N] = '{4, 0, 1, 2, 3};

  logic [N-1:0] pressLog [LOGN];
  logic [N-1:0] levelLog [LOGN];
  logic         validLog [LOGN];
  logic [2:0]   codeLog  [LOGN];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mLevel = '0; mPress = '0; mValid = 1'b0; mCode = '0;
    for (int i = 0; i < N; i++) begin
      pressTime[i] = 0;
      for (int k = 0; k < HLEN; k++) rawHist[i][k] = 1'b0;
    end
  endtask

  // One clock edge of the key rules: accept a level after DEB consecutive
  // disagreeing synchronised samples, pulse on press and on the repeat schedule.
  task automatic modelStep(input logic [N-1:0] raw);
    logic [N-1:0] newLevel, newPress;
    logic         newValid;
    logic [2:0]   newCode;
    bit           allDiff;
    int           age;
    tNow++;
    newValid = |mPress;
    newCode  = mCode;
    for (int p = N - 1; p >= 0; p--) if (mPress[prio[p]]) newCode = 3'(prio[p]);
    newPress = '0;
    newLevel = mLevel;
    for (int i = 0; i < N; i++) begin
      for (int k = HLEN - 1; k > 0; k--) rawHist[i][k] = rawHist[i][k-1];
      rawHist[i][0] = raw[i];
      allDiff = 1'b1;
      for (int k = 2; k < HLEN; k++) if (rawHist[i][k] == mLevel[i]) allDiff = 1'b0;
      if (allDiff) newLevel[i] = ~mLevel[i];
      if (newLevel[i] && !mLevel[i]) begin
        newPress[i]  = 1'b1;
        pressTime[i] = tNow;
      end else if (newLevel[i] && mLevel[i] && i != 4) begin
        age = tNow - pressTime[i];
        if (age == DLY || (age > DLY && (age - DLY) % RATE == 0)) newPress[i] = 1'b1;
      end
    end
    mLevel = newLevel; mPress = newPress; mValid = newValid; mCode = newCode;
  endtask

  task automatic applyStimulus(input logic [N-1:0] raw);
    btn_raw = raw;
    modelStep(raw);
    @(negedge CLK);
    checkOutput("level", 32'(btn_level), 32'(mLevel));
    checkOutput("press", 32'(btn_press), 32'(mPress));
    checkOutput("valid", 32'(key_valid), 32'(mValid));
    checkOutput("code",  32'(key_code),  32'(mCode));
  endtask

  task automatic doReset(input int cycles);
    RST = 1'b1;
    #1;
    checkOutput("rstLevel", 32'(btn_level), 0);
    checkOutput("rstPress", 32'(btn_press), 0);
    checkOutput("rstValid", 32'(key_valid), 0);
    checkOutput("rstCode",  32'(key_code),  0);
    repeat (cycles) begin
      @(negedge CLK);
      checkOutput("rstHoldLevel", 32'(btn_level), 0);
      checkOutput("rstHoldPress", 32'(btn_press), 0);
      checkOutput("rstHoldValid", 32'(key_valid), 0);
    end
    RST = 1'b0;
    modelReset();
  endtask

  task automatic runScenario(input logic [N-1:0] pattern, input int hold, input int total);
    for (int idx = 1; idx <= total; idx++) begin
      applyStimulus(idx <= hold ? pattern : '0);
      pressLog[idx] = btn_press;
      levelLog[idx] = btn_level;
      validLog[idx] = key_valid;
      codeLog[idx]  = key_code;
    end
  endtask

  function automatic int countPress(input int b, input int total);
    int c = 0;
    for (int idx = 1; idx <= total; idx++) if (pressLog[idx][b]) c++;
    return c;
  endfunction

  function automatic int countValid(input int total);
    int c = 0;
    for (int idx = 1; idx <= total; idx++) if (validLog[idx]) c++;
    return c;
  endfunction

  function automatic int countLevel(input int b, input int total);
    int c = 0;
    for (int idx = 1; idx <= total; idx++) if (levelLog[idx][b]) c++;
    return c;
  endfunction

  function automatic int nthPress(input int b, input int n, input int total);
    int c = 0;
    for (int idx = 1; idx <= total; idx++) begin
      if (pressLog[idx][b]) begin
        c++;
        if (c == n) return idx;
      end
    end
    return -1;
  endfunction

  initial begin
    logic [N-1:0] cur;
    int           slowness;
    btn_raw = '0;
    modelReset();
    @(negedge CLK);
    doReset(2);

    // Short glitch must never reach the level
    runScenario(5'b00001, 3, 20);
    checkOutput("glitchPress", countPress(0, 20), 0);
    checkOutput("glitchLevel", countLevel(0, 20), 0);
    checkOutput("glitchValid", countValid(20), 0);

    // Clean press/release on L
    runScenario(5'b00100, 12, 30);
    checkOutput("cleanRise",   nthPress(2, 1, 30), 6);
    checkOutput("cleanVector", 32'(pressLog[6]), 32'(5'b00100));
    checkOutput("cleanCount",  countPress(2, 30), 1);
    checkOutput("cleanValid",  32'(validLog[7]), 1);
    checkOutput("cleanCode",   32'(codeLog[7]), 2);
    checkOutput("cleanHigh",   countLevel(2, 30), 12);

    // Auto-repeat on D
    runScenario(5'b00010, 60, 80);
    checkOutput("repCount",  countPress(1, 80), 6);
    checkOutput("repSecond", nthPress(1, 2, 80), 26);
    checkOutput("repThird",  nthPress(1, 3, 80), 34);
    checkOutput("repLast",   nthPress(1, 6, 80), 58);
    checkOutput("repValid",  countValid(80), 6);
    checkOutput("repCode",   32'(codeLog[27]), 1);

    // C never repeats
    runScenario(5'b10000, 60, 80);
    checkOutput("cCount", countPress(4, 80), 1);
    checkOutput("cValid", countValid(80), 1);
    checkOutput("cCode",  32'(codeLog[7]), 4);

    // Simultaneous presses
    runScenario(5'b01001, 12, 30);
    checkOutput("simVector", 32'(pressLog[6]), 32'(5'b01001));
    checkOutput("simValid",  countValid(30), 1);
    checkOutput("simCode",   32'(codeLog[7]), 0);
    runScenario(5'b10001, 12, 30);
    checkOutput("simCVector", 32'(pressLog[6]), 32'(5'b10001));
    checkOutput("simCCode",   32'(codeLog[7]), 4);

    // Reset in the middle of a held R
    runScenario(5'b01000, 16, 16);
    doReset(2);
    runScenario(5'b01000, 40, 60);
    checkOutput("rstFirst",  nthPress(3, 1, 60), 6);
    checkOutput("rstSecond", nthPress(3, 2, 60), 26);

    // Random activity: fast bouncy phase, then slow holds with occasional resets
    cur = '0;
    for (int c = 0; c < 2400; c++) begin
      slowness = (c < 600) ? 3 : 30;
      for (int i = 0; i < N; i++) if ($urandom_range(0, slowness - 1) == 0) cur[i] = ~cur[i];
      if (c >= 600 && $urandom_range(0, 399) == 0) doReset(int'($urandom_range(1, 3)));
      applyStimulus(cur);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
